// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory fetch handshake between the fetch unit and imem.
//   im_req   : fetch request (master -> slave)
//   im_addr  : word-aligned byte address of the fetch (master -> slave)
//   im_ready : fetch completes this cycle, im_rdata valid (slave -> master)
//   im_rdata : fetched instruction word (slave -> master)
interface fetch_redirect_unit_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic [31:0] im_rdata;

   modport master (output im_req, output im_addr, input im_ready, input im_rdata);
   modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);
endinterface

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch and PC redirect front end: owns the PC, the imem request
// handshake, a one-entry skid buffer and the IF/ID register. Resolves j, jal,
// jr, beq and bne in ID with no delay slot (wrong-path slot is squashed).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   im                : imem fetch handshake (master side)
//   id_stall          : hazard unit holds ID and PC
//   jump, Branch      : decoder outputs for the instruction in ID
//   rs_data, rt_data  : forwarded ID operands
//   instr, OpCode, funct, id_pc_plus4 : IF/ID contents
//   JumpInterrupt     : ID slot is a bubble or squashed
//   misalign          : one-cycle pulse, jr target had nonzero low bits
module fetch_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst,
   fetch_redirect_unit_if.master        im,
   input  logic                         id_stall,
   input  logic                         jump,
   input  logic [2:0]                   Branch,
   input  logic [31:0]                  rs_data,
   input  logic [31:0]                  rt_data,
   output logic [31:0]                  instr,
   output logic [5:0]                   OpCode,
   output logic [5:0]                   funct,
   output logic [31:0]                  id_pc_plus4,
   output logic                         JumpInterrupt,
   output logic                         misalign
);

   localparam int unsigned XLEN = 32;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic              req_q, req_d;
   logic              discard_q, discard_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   pc4_q, pc4_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
   logic [XLEN-1:0]   skid_pc4_q, skid_pc4_d;
   logic              mis_q, mis_d;

   logic              fire;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   br_off;
   logic              taken;
   logic              is_jr;
   logic              redirect;
   logic [XLEN-1:0]   redir_target;

   assign fire     = req_q && im.im_ready;
   assign pc_plus4 = pc_q + XLEN'(4);
   assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // Redirect decode for the instruction in ID; jr has priority over j/jal.
   always_comb begin
      taken        = 1'b0;
      is_jr        = 1'b0;
      redir_target = pc4_q + br_off;
      if (Branch == 3'b111) begin
         taken        = 1'b1;
         is_jr        = 1'b1;
         redir_target = {rs_data[31:2], 2'b00};
      end else if (Branch == 3'b011 || jump) begin
         taken        = 1'b1;
         redir_target = {pc4_q[31:28], instr_q[25:0], 2'b00};
      end else if (Branch == 3'b010) begin
         taken = (rs_data == rt_data);
      end else if (Branch == 3'b001) begin
         taken = (rs_data != rt_data);
      end
      redirect = valid_q && !id_stall && taken;
   end

   // Next-state logic for PC, fetch handshake, skid buffer and IF/ID.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      discard_d    = discard_q;
      mis_d        = 1'b0;

      if (redirect) begin
         // Squash the ID slot; an in-flight fetch that is not completing now
         // must still be drained before the target can be requested.
         pc_d      = redir_target;
         valid_d   = 1'b0;
         instr_d   = NOP_WORD;
         state_d   = ST_FETCH;
         discard_d = req_q && !im.im_ready;
         mis_d     = is_jr && (rs_data[1:0] != 2'b00);
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (fire && discard_q) begin
                  discard_d = 1'b0;
                  if (!id_stall) begin
                     valid_d = 1'b0;
                     instr_d = NOP_WORD;
                  end
               end else if (fire) begin
                  if (!id_stall) begin
                     instr_d = im.im_rdata;
                     pc4_d   = pc_plus4;
                     valid_d = 1'b1;
                  end else begin
                     skid_instr_d = im.im_rdata;
                     skid_pc4_d   = pc_plus4;
                     state_d      = ST_HOLD;
                  end
                  pc_d = pc_plus4;
               end else if (!id_stall) begin
                  valid_d = 1'b0;
                  instr_d = NOP_WORD;
               end
            end
            ST_HOLD: begin
               if (!id_stall) begin
                  instr_d = skid_instr_q;
                  pc4_d   = skid_pc4_q;
                  valid_d = 1'b1;
                  state_d = ST_FETCH;
               end
            end
            default: begin
               state_d = ST_FETCH;
            end
         endcase
      end

      req_d = (state_d == ST_FETCH);
      // Address stays on the abandoned request until it completes.
      addr_d = discard_d ? addr_q : pc_d;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         discard_q    <= 1'b0;
         instr_q      <= NOP_WORD;
         pc4_q        <= '0;
         valid_q      <= 1'b0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
         mis_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         discard_q    <= discard_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         mis_q        <= mis_d;
      end
   end

   assign im.im_req     = req_q;
   assign im.im_addr    = addr_q;
   assign instr         = instr_q;
   assign OpCode        = instr_q[31:26];
   assign funct         = instr_q[5:0];
   assign id_pc_plus4   = pc4_q;
   assign JumpInterrupt = ~valid_q;
   assign misalign      = mis_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: directed vector table, directed
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_fetch_redirect_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_stall;
   logic        jump;
   logic [2:0]  Branch;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] instr;
   logic [5:0]  OpCode;
   logic [5:0]  funct;
   logic [31:0] id_pc_plus4;
   logic        JumpInterrupt;
   logic        misalign;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_redirect_unit_if imb ();

   fetch_redirect_unit dut (
      .clk           (clk),
      .rst           (rst),
      .im            (imb),
      .id_stall      (id_stall),
      .jump          (jump),
      .Branch        (Branch),
      .rs_data       (rs_data),
      .rt_data       (rt_data),
      .instr         (instr),
      .OpCode        (OpCode),
      .funct         (funct),
      .id_pc_plus4   (id_pc_plus4),
      .JumpInterrupt (JumpInterrupt),
      .misalign      (misalign)
   );

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [31:0] rdata;
      logic        stall;
      logic        jmp;
      logic [2:0]  br;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ji;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_mis;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rdy, input logic [31:0] rd,
                               input logic st, input logic jm, input logic [2:0] b,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic e_req, input logic [31:0] e_addr, input logic e_ji,
                               input logic [31:0] e_ins, input logic [31:0] e_pc4, input logic e_mis);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.rdata = rd; v.stall = st; v.jmp = jm; v.br = b;
      v.rs = rs; v.rt = rt; v.e_req = e_req; v.e_addr = e_addr; v.e_ji = e_ji;
      v.e_instr = e_ins; v.e_pc4 = e_pc4; v.e_mis = e_mis;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Address is only meaningful while requesting; pc4 only for a valid slot.
   task automatic check_outs(input string tag, input logic r, input logic e_req,
                             input logic [31:0] e_addr, input logic e_ji,
                             input logic [31:0] e_ins, input logic [31:0] e_pc4,
                             input logic e_mis);
      logic [31:0] ins;
      ins = e_ins;
      chk({tag, " im_req"}, 32'(imb.im_req), 32'(e_req));
      if (e_req || r) chk({tag, " im_addr"}, imb.im_addr, e_addr);
      chk({tag, " JumpInterrupt"}, 32'(JumpInterrupt), 32'(e_ji));
      chk({tag, " instr"}, instr, ins);
      chk({tag, " OpCode"}, 32'(OpCode), 32'(ins[31:26]));
      chk({tag, " funct"}, 32'(funct), 32'(ins[5:0]));
      if (!e_ji || r) chk({tag, " id_pc_plus4"}, id_pc_plus4, e_pc4);
      chk({tag, " misalign"}, 32'(misalign), 32'(e_mis));
   endtask

   task automatic drive(input logic r, input logic rdy, input logic [31:0] rd, input logic st,
                        input logic jm, input logic [2:0] b, input logic [31:0] rs,
                        input logic [31:0] rt);
      rst = r; imb.im_ready = rdy; imb.im_rdata = rd; id_stall = st;
      jump = jm; Branch = b; rs_data = rs; rt_data = rt;
   endtask

   task automatic apply(input string tag, input vec_t v);
      drive(v.rst, v.rdy, v.rdata, v.stall, v.jmp, v.br, v.rs, v.rt);
      @(posedge clk);
      #1;
      check_outs(tag, v.rst, v.e_req, v.e_addr, v.e_ji, v.e_instr, v.e_pc4, v.e_mis);
   endtask

   // ---------------- reference model ----------------
   localparam logic [31:0] M_RESET_PC = 32'h0000_3000;
   logic [31:0] m_pc, m_addr, m_instr, m_pc4;
   bit          m_req, m_disc, m_valid, m_mis;
   logic [63:0] m_skid[$];

   task automatic m_reset();
      m_pc = M_RESET_PC; m_addr = M_RESET_PC; m_req = 0; m_disc = 0;
      m_valid = 0; m_instr = 32'h0; m_pc4 = 32'h0; m_mis = 0; m_skid.delete();
   endtask

   function automatic logic [32:0] m_redirect(input logic jm, input logic [2:0] b,
                                              input logic [31:0] rs, input logic [31:0] rt,
                                              input logic [31:0] ins, input logic [31:0] pc4);
      logic [31:0] btgt;
      btgt = pc4 + 32'($signed(ins[15:0])) * 32'd4;
      if (b == 3'b111) return {1'b1, rs & 32'hFFFF_FFFC};
      if (b == 3'b011 || jm) return {1'b1, pc4[31:28], ins[25:0], 2'b00};
      if (b == 3'b010) return {rs == rt, btgt};
      if (b == 3'b001) return {rs != rt, btgt};
      return 33'h0;
   endfunction

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
   endfunction

   task automatic m_step(input logic r, input logic rdy, input logic [31:0] rd, input logic st,
                         input logic jm, input logic [2:0] b, input logic [31:0] rs,
                         input logic [31:0] rt);
      logic [32:0] rr;
      bit done;
      if (r) begin
         m_reset();
         return;
      end
      rr   = m_redirect(jm, b, rs, rt, m_instr, m_pc4);
      done = m_req && rdy;
      m_mis = 0;
      if (m_valid && !st && rr[32]) begin
         m_pc = rr[31:0];
         m_valid = 0; m_instr = 32'h0;
         m_skid.delete();
         m_disc = m_req && !rdy;
         if (!m_disc) m_addr = m_pc;
         m_mis = (b == 3'b111) && (rs[1:0] != 2'b00);
         m_req = 1;
      end else if (m_skid.size() != 0) begin
         if (!st) begin
            {m_instr, m_pc4} = m_skid.pop_front();
            m_valid = 1; m_req = 1; m_addr = m_pc;
         end
      end else begin
         if (done && m_disc) begin
            m_disc = 0;
            if (!st) begin m_valid = 0; m_instr = 32'h0; end
         end else if (done) begin
            if (!st) begin m_instr = rd; m_pc4 = m_pc + 32'd4; m_valid = 1; end
            else m_skid.push_back({rd, m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
         end else if (!st) begin
            m_valid = 0; m_instr = 32'h0;
         end
         m_req = (m_skid.size() == 0);
         if (!m_disc) m_addr = m_pc;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vec_t tbl[$];
      logic [2:0] brs[9];

      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b1, 1'b0, 32'h3000, 1'b1, 32'h0, 32'h0, 1'b0);

      // zero-wait sequential fetch
      tbl.push_back(mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3000,1,32'h0,32'h0,0));
      tbl.push_back(mk(0,1,32'h3C010001,0,0,3'b000,0,0, 1,32'h3004,0,32'h3C010001,32'h3004,0));
      tbl.push_back(mk(0,1,32'h34210002,0,0,3'b000,0,0, 1,32'h3008,0,32'h34210002,32'h3008,0));
      tbl.push_back(mk(0,1,32'h00000000,0,0,3'b000,0,0, 1,32'h300C,0,32'h0,32'h300C,0));
      // beq taken at pc+4 0x3008, then bne not taken
      tbl.push_back(mk(1,0,32'h0,0,0,3'b000,0,0,        0,32'h3000,1,32'h0,32'h0,0));
      tbl.push_back(mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3000,1,32'h0,32'h0,0));
      tbl.push_back(mk(0,1,32'h00000000,0,0,3'b000,0,0, 1,32'h3004,0,32'h0,32'h3004,0));
      tbl.push_back(mk(0,1,32'h10210003,0,0,3'b000,0,0, 1,32'h3008,0,32'h10210003,32'h3008,0));
      tbl.push_back(mk(0,1,32'hAAAA0000,0,0,3'b010,5,5, 1,32'h3014,1,32'h0,32'h0,0));
      tbl.push_back(mk(0,1,32'h00000020,0,0,3'b000,0,0, 1,32'h3018,0,32'h20,32'h3018,0));
      tbl.push_back(mk(0,1,32'h14210003,0,0,3'b000,0,0, 1,32'h301C,0,32'h14210003,32'h301C,0));
      tbl.push_back(mk(0,1,32'h00000000,0,0,3'b001,5,5, 1,32'h3020,0,32'h0,32'h3020,0));
      // j then jr (misaligned, then aligned)
      tbl.push_back(mk(1,0,32'h0,0,0,3'b000,0,0,        0,32'h3000,1,32'h0,32'h0,0));
      tbl.push_back(mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3000,1,32'h0,32'h0,0));
      tbl.push_back(mk(0,1,32'h08000C10,0,0,3'b000,0,0, 1,32'h3004,0,32'h08000C10,32'h3004,0));
      tbl.push_back(mk(0,1,32'hBBBB0000,0,1,3'b000,0,0, 1,32'h3040,1,32'h0,32'h0,0));
      tbl.push_back(mk(0,1,32'h24420001,0,0,3'b000,0,0, 1,32'h3044,0,32'h24420001,32'h3044,0));
      tbl.push_back(mk(0,1,32'hCCCC0000,0,0,3'b111,32'h3022,0, 1,32'h3020,1,32'h0,32'h0,1));
      tbl.push_back(mk(0,1,32'h00000021,0,0,3'b000,0,0, 1,32'h3024,0,32'h21,32'h3024,0));
      tbl.push_back(mk(0,1,32'h00000000,0,0,3'b111,32'h3000,0, 1,32'h3000,1,32'h0,32'h0,0));
      foreach (tbl[i]) apply($sformatf("tbl[%0d]", i), tbl[i]);

      // redirect while the fetch is still waiting: old word must be dropped
      apply("D0", mk(1,0,32'h0,0,0,3'b000,0,0,        0,32'h3000,1,32'h0,32'h0,0));
      apply("D1", mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3000,1,32'h0,32'h0,0));
      apply("D2", mk(0,1,32'h10210003,0,0,3'b000,0,0, 1,32'h3004,0,32'h10210003,32'h3004,0));
      apply("D3", mk(0,0,32'h0,0,0,3'b010,7,7,        1,32'h3004,1,32'h0,32'h0,0));
      apply("D4", mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3004,1,32'h0,32'h0,0));
      apply("D5", mk(0,1,32'hDEAD0000,0,0,3'b000,0,0, 1,32'h3010,1,32'h0,32'h0,0));
      apply("D6", mk(0,1,32'h00000022,0,0,3'b000,0,0, 1,32'h3014,0,32'h22,32'h3014,0));

      // stall during a completing fetch: skid/HOLD, branch blocked by stall
      apply("E0", mk(1,0,32'h0,0,0,3'b000,0,0,        0,32'h3000,1,32'h0,32'h0,0));
      apply("E1", mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3000,1,32'h0,32'h0,0));
      apply("E2", mk(0,1,32'h00000024,0,0,3'b000,0,0, 1,32'h3004,0,32'h24,32'h3004,0));
      apply("E3", mk(0,1,32'h10210003,1,0,3'b010,9,9, 0,32'h0,0,32'h24,32'h3004,0));
      apply("E4", mk(0,0,32'h0,1,0,3'b010,9,9,        0,32'h0,0,32'h24,32'h3004,0));
      apply("E5", mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3008,0,32'h10210003,32'h3008,0));
      apply("E6", mk(0,0,32'h0,1,0,3'b010,9,9,        1,32'h3008,0,32'h10210003,32'h3008,0));
      apply("E7", mk(0,1,32'hEEEE0000,0,0,3'b010,9,9, 1,32'h3014,1,32'h0,32'h0,0));
      apply("E8", mk(0,1,32'h00000025,0,0,3'b000,0,0, 1,32'h3018,0,32'h25,32'h3018,0));

      // reset while a discard is pending must clear it
      apply("F0", mk(1,0,32'h0,0,0,3'b000,0,0,        0,32'h3000,1,32'h0,32'h0,0));
      apply("F1", mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3000,1,32'h0,32'h0,0));
      apply("F2", mk(0,1,32'h10210003,0,0,3'b000,0,0, 1,32'h3004,0,32'h10210003,32'h3004,0));
      apply("F3", mk(0,0,32'h0,0,0,3'b010,3,3,        1,32'h3004,1,32'h0,32'h0,0));
      apply("F4", mk(1,0,32'h0,0,0,3'b000,0,0,        0,32'h3000,1,32'h0,32'h0,0));
      apply("F5", mk(0,0,32'h0,0,0,3'b000,0,0,        1,32'h3000,1,32'h0,32'h0,0));
      apply("F6", mk(0,1,32'h00000026,0,0,3'b000,0,0, 1,32'h3004,0,32'h26,32'h3004,0));

      // randomized traffic against the model
      brs[0] = 3'b000; brs[1] = 3'b000; brs[2] = 3'b000; brs[3] = 3'b001; brs[4] = 3'b010;
      brs[5] = 3'b011; brs[6] = 3'b111; brs[7] = 3'b100; brs[8] = 3'b110;
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      m_reset();
      @(posedge clk);
      #1;
      for (int c = 0; c < 3000; c++) begin
         logic        r_rst, r_rdy, r_st, r_jm;
         logic [2:0]  r_b;
         logic [31:0] r_rd, r_rs, r_rt;
         r_rst = ($urandom_range(0, 199) == 0);
         r_st  = ($urandom_range(0, 3) == 0);
         r_rdy = m_req && ($urandom_range(0, 9) < 6);
         r_rd  = memfn(m_addr);
         r_b   = brs[$urandom_range(0, 8)];
         r_jm  = ($urandom_range(0, 15) == 0);
         r_rs  = $urandom;
         if ($urandom_range(0, 3) != 0) r_rs = r_rs & 32'hFFFF_FFFC;
         r_rt  = ($urandom_range(0, 1) == 0) ? r_rs : 32'($urandom);
         drive(r_rst, r_rdy, r_rd, r_st, r_jm, r_b, r_rs, r_rt);
         m_step(r_rst, r_rdy, r_rd, r_st, r_jm, r_b, r_rs, r_rt);
         @(posedge clk);
         #1;
         check_outs($sformatf("rnd[%0d]", c), r_rst, m_req, m_addr, !m_valid,
                    m_instr, m_pc4, m_mis);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
